// File: rtl/gl_cmd_seq_if.sv
// Command bus between a GL command producer and the gl_cmd_seq sequencer.
interface gl_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  opcode;
  logic [22:0] imm;
  logic [31:0] bram_addr_in;

  modport master (output cmd_valid, opcode, imm, bram_addr_in, input cmd_ready);
  modport slave  (input cmd_valid, opcode, imm, bram_addr_in, output cmd_ready);
endinterface

// File: rtl/gl_cmd_seq.sv
// gl_cmd_seq: sequences GL commands into matrix-unit control pulses,
// BRAM row fetches and colour/viewport state updates.
module gl_cmd_seq #(
  parameter int DATA_W      = 32,
  parameter int NCH         = 3,
  parameter int MM_LAT      = 15,
  parameter int DIV_LAT     = 2,
  parameter int LOAD_ROWS   = 4,
  parameter int ADDR_STEP   = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  gl_cmd_seq_if.slave             cmd_bus,
  input  logic [4*DATA_W-1:0]     bram_rd_data,
  output logic [31:0]             bram_addr_out,
  output logic [NCH*DATA_W-1:0]   color_out,
  output logic [4*DATA_W-1:0]     viewport_out,
  output logic                    matrix_mode_out,
  output logic                    matrix_mul_en,
  output logic                    matrix_mul_type,
  output logic                    matrix_load_en,
  output logic                    matrix_load_id_en,
  output logic                    push_en,
  output logic                    pop_en,
  output logic                    perspective_div_en,
  output logic                    stack_err
);
  localparam int unsigned T_VTX   = 2*MM_LAT + DIV_LAT + 1;
  localparam int unsigned T_LOAD  = LOAD_ROWS + 1;
  localparam int unsigned T_MAX   = (T_VTX > T_LOAD) ? T_VTX : T_LOAD;
  localparam int          CNT_W   = $clog2(T_MAX + 1);
  localparam int          DEPTH_W = $clog2(STACK_DEPTH + 1);
  // Viewport words 0..3 = x, y, width (640.0), height (480.0)
  localparam logic [4*DATA_W-1:0] VP_RST =
    {DATA_W'(32'h43F0_0000), DATA_W'(32'h4420_0000), {(2*DATA_W){1'b0}}};

  localparam logic [7:0] OP_VERTEX = 8'h03, OP_COLOR = 8'h04, OP_MMODE = 8'h10,
                         OP_MULT = 8'h11, OP_LOADID = 8'h12, OP_LOADM = 8'h13,
                         OP_PUSH = 8'h14, OP_POP = 8'h15, OP_ROTATE = 8'h16,
                         OP_SCALE = 8'h17, OP_TRANSL = 8'h18, OP_VIEWPORT = 8'h19;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {M_MULT, M_VERTEX, M_LOADM, M_COLOR, M_VIEWPORT} mop_e;
  typedef enum logic [1:0] {P_NONE, P_LOADID, P_PUSH, P_POP} pend_e;

  state_e              state_q, state_d;
  mop_e                mop_q, mop_d;
  pend_e               pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         base_q, base_d;
  logic                mode_q, mode_d;
  logic                accept, go;
  logic [31:0]         t, t_last;

  logic                mul_en_q, mul_en_d, mtype_q, mtype_d, mmode_q, mmode_d;
  logic                lden_q, lden_d, lid_q, lid_d, push_q, push_d, pop_q, pop_d;
  logic                div_q, div_d, err_q, err_d;
  logic [31:0]         addr_q, addr_d;
  logic [NCH*DATA_W-1:0] color_q, color_d;
  logic [4*DATA_W-1:0] vp_q, vp_d;
  logic [DEPTH_W-1:0]  depth_q [2];
  logic [DEPTH_W-1:0]  depth_d [2];

  // Only imm[0] carries meaning for this command set.
  logic imm_unused;
  assign imm_unused = ^cmd_bus.imm[22:1];

  assign accept           = (state_q == IDLE) && cmd_bus.cmd_valid;
  assign cmd_bus.cmd_ready = (state_q == IDLE);
  // t is the index of the upcoming edge relative to the accept edge.
  assign t = 32'(cnt_q) + 32'd1;

  // State register: FSM, phase counter and captured command context.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mop_q   <= M_MULT;
      pend_q  <= P_NONE;
      cnt_q   <= '0;
      base_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mop_q   <= mop_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state: decode accepted opcodes; leave RUN one edge before the final phase.
  always_comb begin
    state_d = state_q;
    mop_d   = mop_q;
    pend_d  = P_NONE;
    cnt_d   = cnt_q;
    base_d  = base_q;
    mode_d  = mode_q;
    go      = 1'b0;
    unique case (mop_q)
      M_MULT:   t_last = 32'(MM_LAT + 1);
      M_VERTEX: t_last = 32'(T_VTX);
      M_LOADM:  t_last = 32'(T_LOAD);
      default:  t_last = 32'd2;
    endcase
    unique case (state_q)
      IDLE: if (accept) begin
        case (cmd_bus.opcode)
          OP_MMODE:  mode_d = cmd_bus.imm[0];
          OP_LOADID: pend_d = P_LOADID;
          OP_PUSH:   pend_d = P_PUSH;
          OP_POP:    pend_d = P_POP;
          OP_MULT, OP_ROTATE, OP_SCALE, OP_TRANSL: begin go = 1'b1; mop_d = M_MULT; end
          OP_VERTEX:   begin go = 1'b1; mop_d = M_VERTEX;   end
          OP_LOADM:    begin go = 1'b1; mop_d = M_LOADM;    end
          OP_COLOR:    begin go = 1'b1; mop_d = M_COLOR;    end
          OP_VIEWPORT: begin go = 1'b1; mop_d = M_VIEWPORT; end
          default: ;
        endcase
        if (go) begin
          state_d = RUN;
          cnt_d   = '0;
          base_d  = cmd_bus.bram_addr_in;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (t == t_last - 32'd1) state_d = DONE;
      end
      DONE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: pulses and level updates due on the upcoming edge.
  always_comb begin
    mul_en_d = 1'b0; lden_d = 1'b0; lid_d = 1'b0; push_d = 1'b0;
    pop_d    = 1'b0; div_d  = 1'b0; err_d = 1'b0;
    mtype_d  = mtype_q;
    mmode_d  = mmode_q;
    addr_d   = addr_q;
    color_d  = color_q;
    vp_d     = vp_q;
    depth_d  = depth_q;
    unique case (pend_q)
      P_LOADID: begin lid_d = 1'b1; mmode_d = mode_q; end
      P_PUSH:
        if (depth_q[mode_q] == DEPTH_W'(STACK_DEPTH)) err_d = 1'b1;
        else begin push_d = 1'b1; depth_d[mode_q] = depth_q[mode_q] + DEPTH_W'(1); end
      P_POP:
        if (depth_q[mode_q] == '0) err_d = 1'b1;
        else begin pop_d = 1'b1; depth_d[mode_q] = depth_q[mode_q] - DEPTH_W'(1); end
      default: ;
    endcase
    if (state_q != IDLE) begin
      unique case (mop_q)
        M_MULT:
          if (t == 32'd1) begin mul_en_d = 1'b1; mtype_d = 1'b1; mmode_d = mode_q; end
        M_VERTEX: begin
          // Modelview transform first, then projection, then the divide.
          if (t == 32'd1)             begin mul_en_d = 1'b1; mtype_d = 1'b0; mmode_d = 1'b1; end
          if (t == 32'(MM_LAT + 1))   begin mul_en_d = 1'b1; mtype_d = 1'b0; mmode_d = 1'b0; end
          if (t == 32'(2*MM_LAT + 1)) div_d = 1'b1;
        end
        M_LOADM:
          if (t <= 32'(LOAD_ROWS)) begin
            lden_d  = 1'b1;
            mmode_d = mode_q;
            addr_d  = base_q + 32'(cnt_q) * 32'(ADDR_STEP);
          end
        M_COLOR: begin
          if (t == 32'd1) addr_d  = base_q;
          if (t == 32'd2) color_d = bram_rd_data[NCH*DATA_W-1:0];
        end
        M_VIEWPORT: begin
          if (t == 32'd1) addr_d = base_q;
          if (t == 32'd2) vp_d   = bram_rd_data;
        end
        default: ;
      endcase
    end
  end

  // Output registers and per-mode stack depth counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      mul_en_q <= 1'b0; mtype_q <= 1'b0; mmode_q <= 1'b0; lden_q <= 1'b0;
      lid_q    <= 1'b0; push_q  <= 1'b0; pop_q   <= 1'b0; div_q  <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      color_q  <= '0;
      vp_q     <= VP_RST;
      depth_q[0] <= '0;
      depth_q[1] <= '0;
    end else begin
      mul_en_q <= mul_en_d; mtype_q <= mtype_d; mmode_q <= mmode_d; lden_q <= lden_d;
      lid_q    <= lid_d;    push_q  <= push_d;  pop_q   <= pop_d;   div_q  <= div_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      color_q  <= color_d;
      vp_q     <= vp_d;
      depth_q  <= depth_d;
    end
  end

  assign bram_addr_out      = addr_q;
  assign color_out          = color_q;
  assign viewport_out       = vp_q;
  assign matrix_mode_out    = mmode_q;
  assign matrix_mul_en      = mul_en_q;
  assign matrix_mul_type    = mtype_q;
  assign matrix_load_en     = lden_q;
  assign matrix_load_id_en  = lid_q;
  assign push_en            = push_q;
  assign pop_en             = pop_q;
  assign perspective_div_en = div_q;
  assign stack_err          = err_q;
endmodule

// File: tb/tb_gl_cmd_seq.sv
// Testbench for gl_cmd_seq: directed and random commands against a timeline model.
module tb_gl_cmd_seq;
  localparam int DW = 32, NCH = 3, MM = 4, DIV = 2, LR = 4, STEP = 16, SD = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gl_cmd_seq_if bus();
  logic [4*DW-1:0]   rd;
  logic [31:0]       bram_addr_out;
  logic [NCH*DW-1:0] color_out;
  logic [4*DW-1:0]   viewport_out;
  logic matrix_mode_out, matrix_mul_en, matrix_mul_type, matrix_load_en, matrix_load_id_en;
  logic push_en, pop_en, perspective_div_en, stack_err;

  gl_cmd_seq #(.DATA_W(DW), .NCH(NCH), .MM_LAT(MM), .DIV_LAT(DIV), .LOAD_ROWS(LR),
               .ADDR_STEP(STEP), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .cmd_bus(bus), .bram_rd_data(rd),
    .bram_addr_out(bram_addr_out), .color_out(color_out), .viewport_out(viewport_out),
    .matrix_mode_out(matrix_mode_out), .matrix_mul_en(matrix_mul_en),
    .matrix_mul_type(matrix_mul_type), .matrix_load_en(matrix_load_en),
    .matrix_load_id_en(matrix_load_id_en), .push_en(push_en), .pop_en(pop_en),
    .perspective_div_en(perspective_div_en), .stack_err(stack_err));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit          m_mode, m_mode_out, m_type;
  int          m_depth [2];
  logic [31:0] m_addr;
  logic [NCH*DW-1:0] m_color;
  logic [4*DW-1:0]   m_vp;

  task automatic model_reset();
    m_mode = 1'b0; m_mode_out = 1'b0; m_type = 1'b0;
    m_depth[0] = 0; m_depth[1] = 0;
    m_addr = 32'h0; m_color = '0;
    m_vp = {32'h43F0_0000, 32'h4420_0000, 64'h0};
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tg, input bit e_rdy, input bit e_mul, input bit e_lid,
                           input bit e_push, input bit e_pop, input bit e_div, input bit e_err,
                           input bit e_lden);
    chk1({tg, " cmd_ready"}, bus.cmd_ready, e_rdy);
    chk1({tg, " mul_en"}, matrix_mul_en, e_mul);
    chk1({tg, " load_id_en"}, matrix_load_id_en, e_lid);
    chk1({tg, " push_en"}, push_en, e_push);
    chk1({tg, " pop_en"}, pop_en, e_pop);
    chk1({tg, " div_en"}, perspective_div_en, e_div);
    chk1({tg, " stack_err"}, stack_err, e_err);
    chk1({tg, " load_en"}, matrix_load_en, e_lden);
    chk1({tg, " mul_type"}, matrix_mul_type, m_type);
    chk1({tg, " mode_out"}, matrix_mode_out, m_mode_out);
    chkw({tg, " addr"}, 128'(bram_addr_out), 128'(m_addr));
    chkw({tg, " color"}, 128'(color_out), 128'(m_color));
    chkw({tg, " viewport"}, viewport_out, m_vp);
  endtask

  // Issue one command starting at a negedge; check every cycle until it completes.
  task automatic do_cmd(input logic [7:0] op, input logic [22:0] im, input logic [31:0] addr,
                        input logic [127:0] data);
    bit mul, vtx, ldm, col, vp, multi;
    bit e_mul, e_lid, e_push, e_pop, e_div, e_err, e_lden;
    int tf;
    string tg;
    mul = op inside {8'h11, 8'h16, 8'h17, 8'h18};
    vtx = (op == 8'h03); ldm = (op == 8'h13); col = (op == 8'h04); vp = (op == 8'h19);
    multi = mul | vtx | ldm | col | vp;
    tf = mul ? 1 + MM : vtx ? 1 + 2*MM + DIV : ldm ? 1 + LR : (col | vp) ? 2 : 1;
    bus.cmd_valid = 1'b1; bus.opcode = op; bus.imm = im; bus.bram_addr_in = addr; rd = data;
    chk1($sformatf("op%02h accept", op), bus.cmd_ready, 1'b1);
    @(posedge clk);
    if (op == 8'h10) m_mode = im[0];
    for (int n = 0; n <= tf; n++) begin
      if (n > 0) @(posedge clk);
      @(negedge clk);
      if (n == 0) begin
        // While busy, present a PUSH that must be ignored.
        if (multi) begin bus.opcode = 8'h14; bus.imm = 23'($urandom); end
        else bus.cmd_valid = 1'b0;
      end
      if (multi && n == tf - 1) bus.cmd_valid = 1'b0;
      e_mul = 0; e_lid = 0; e_push = 0; e_pop = 0; e_div = 0; e_err = 0; e_lden = 0;
      if (n == 1 && (mul || vtx)) begin
        e_mul = 1; m_type = mul; m_mode_out = mul ? m_mode : 1'b1;
      end
      if (vtx && n == 1 + MM) begin e_mul = 1; m_type = 1'b0; m_mode_out = 1'b0; end
      if (vtx && n == 1 + 2*MM) e_div = 1;
      if (ldm && n >= 1 && n <= LR) begin
        e_lden = 1; m_mode_out = m_mode; m_addr = addr + 32'(n - 1) * 32'(STEP);
      end
      if ((col || vp) && n == 1) m_addr = addr;
      if (col && n == 2) m_color = data[NCH*DW-1:0];
      if (vp && n == 2) m_vp = data;
      if (op == 8'h12 && n == 1) begin e_lid = 1; m_mode_out = m_mode; end
      if (op == 8'h14 && n == 1) begin
        if (m_depth[m_mode] == SD) e_err = 1;
        else begin e_push = 1; m_depth[m_mode]++; end
      end
      if (op == 8'h15 && n == 1) begin
        if (m_depth[m_mode] == 0) e_err = 1;
        else begin e_pop = 1; m_depth[m_mode]--; end
      end
      tg = $sformatf("op%02h +%0d", op, n);
      check_all(tg, !multi || n >= tf, e_mul, e_lid, e_push, e_pop, e_div, e_err, e_lden);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0]   ops [16];
  logic [7:0]   op;
  logic [31:0]  a;
  logic [127:0] d;
  bit           ep, ee;

  initial begin
    ops = '{8'h10, 8'h12, 8'h11, 8'h16, 8'h17, 8'h18, 8'h03, 8'h13,
            8'h04, 8'h19, 8'h14, 8'h15, 8'h14, 8'h00, 8'h01, 8'h1A};
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.opcode = '0; bus.imm = '0; bus.bram_addr_in = '0; rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // A MATRIXMODE presented during reset must be discarded.
    bus.cmd_valid = 1'b1; bus.opcode = 8'h10; bus.imm = 23'd1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; bus.cmd_valid = 1'b0;
    model_reset();
    check_all("reset", 1, 0, 0, 0, 0, 0, 0, 0);

    do_cmd(8'h12, 23'd0, 32'h0, '0);                 // curr_mode still 0
    do_cmd(8'h03, 23'd0, 32'h0, '0);                 // VERTEX timeline
    do_cmd(8'h13, 23'd0, 32'h0000_0100, '0);         // rows 0x100..0x130
    do_cmd(8'h13, 23'd0, 32'hFFFF_FFE0, '0);         // address wrap
    do_cmd(8'h04, 23'd0, 32'h0000_2000,
           {32'h0, 32'h3E80_0000, 32'h3F00_0000, 32'h3F80_0000});
    do_cmd(8'h19, 23'd0, 32'h0000_3000, {$urandom, $urandom, $urandom, $urandom});

    do_cmd(8'h10, 23'd1, 32'h0, '0);                 // modelview
    do_cmd(8'h15, 23'd0, 32'h0, '0);                 // underflow
    do_cmd(8'h14, 23'd0, 32'h0, '0);
    do_cmd(8'h15, 23'd0, 32'h0, '0);

    do_cmd(8'h10, 23'd0, 32'h0, '0);                 // projection
    bus.cmd_valid = 1'b1; bus.opcode = 8'h14; bus.imm = '0;
    for (int k = 0; k <= 9; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 8) bus.cmd_valid = 1'b0;
      if (k > 0) begin
        ep = 0; ee = 0;
        if (m_depth[0] == SD) ee = 1;
        else begin ep = 1; m_depth[0]++; end
        check_all($sformatf("b2b push%0d", k - 1), 1, 0, 0, ep, 0, 0, ee, 0);
      end
    end
    do_cmd(8'h10, 23'd1, 32'h0, '0);
    do_cmd(8'h15, 23'd0, 32'h0, '0);                 // modelview depth 0
    do_cmd(8'h10, 23'd0, 32'h0, '0);
    do_cmd(8'h14, 23'd0, 32'h0, '0);                 // projection depth 8
    do_cmd(8'h15, 23'd0, 32'h0, '0);

    // Reset in the middle of a MULT.
    do_cmd(8'h10, 23'd1, 32'h0, '0);
    bus.cmd_valid = 1'b1; bus.opcode = 8'h11;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_type = 1'b1; m_mode_out = 1'b1;
    check_all("mult +1", 0, 1, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all("mult reset", 1, 0, 0, 0, 0, 0, 0, 0);
    do_cmd(8'h12, 23'd0, 32'h0, '0);

    do_cmd(8'h00, 23'h7F_FFFF, 32'hDEAD_BEEF, '0);   // BEGIN
    do_cmd(8'h01, 23'h1, 32'h0, '0);                 // END
    do_cmd(8'h02, 23'h1, 32'h0, '0);                 // FRUSTUM

    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) op = 8'($urandom);
      a = $urandom;
      if (i % 5 == 0) a = 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
      d = {$urandom, $urandom, $urandom, $urandom};
      do_cmd(op, 23'($urandom), a, d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gl_cmd_seq.md
GL_CMD_SEQ -- requirements
Module: gl_cmd_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the width of one float word.
REQ-002 SHALL have parameter NCH, default 3, giving the number of colour channels captured (1..4).
REQ-003 SHALL have parameter MM_LAT, default 15, giving the matrix-multiply latency in cycles (>=2).
REQ-004 SHALL have parameter DIV_LAT, default 2, giving the perspective-divide latency in cycles (>=1).
REQ-005 SHALL have parameter LOAD_ROWS, default 4, giving the number of BRAM rows per matrix load.
REQ-006 SHALL have parameter ADDR_STEP, default 16, giving the byte increment between matrix rows.
REQ-007 SHALL have parameter STACK_DEPTH, default 8, giving the maximum entries per matrix stack.
REQ-008 SHALL have ports as follows; there is one clock and reset is synchronous and active-high:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous, active-high reset
  cmd_valid  in  1  command present
  cmd_ready  out  1  sequencer can accept a command
  opcode  in  8  command opcode
  imm  in  23  immediate operand
  bram_addr_in  in  32  operand base address
  bram_rd_data  in  4*DATA_W  BRAM row; word i in bits [i*DATA_W +: DATA_W]
  bram_addr_out  out  32  BRAM read address
  color_out  out  NCH*DATA_W  current colour, same word packing as bram_rd_data
  viewport_out  out  4*DATA_W  viewport: x, y, width, height as words 0..3
  matrix_mode_out  out  1  matrix target (1 = modelview, 0 = projection)
  matrix_mul_en, matrix_mul_type, matrix_load_en, matrix_load_id_en, push_en, pop_en, perspective_div_en  out  1 each  matrix unit controls
  stack_err  out  1  one-cycle pulse on stack overflow or underflow

Function
REQ-009 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; that edge is cycle A, and "+n" means the n-th edge after A.
REQ-010 SHALL use a state machine with states IDLE, RUN and DONE, and SHALL hold cmd_ready high only in IDLE.
REQ-011 SHALL complete single-cycle opcodes (MATRIXMODE, LOADID, PUSH, POP, NOP) in IDLE, keeping cmd_ready high so back-to-back accepts are possible.
REQ-012 SHALL, on multi-cycle opcodes, enter RUN at A with cmd_ready low from +1, go to DONE on the final phase, and return to IDLE with cmd_ready high on the following edge.
REQ-013 SHALL make every pulse output (mul_en, load_id_en, push_en, pop_en, perspective_div_en, stack_err) high for exactly one cycle per event.
REQ-014 SHALL, for opcode 0x10 MATRIXMODE, set internal curr_mode <= imm[0] at A.
REQ-015 SHALL, for opcode 0x12 LOADID, at +1 pulse matrix_load_id_en with matrix_mode_out = curr_mode.
REQ-016 SHALL, for opcodes 0x11 MULT, 0x16 ROTATE, 0x17 SCALE and 0x18 TRANSLATE, at +1 pulse matrix_mul_en with mul_type = 1 and mode_out = curr_mode, and raise cmd_ready at +1+MM_LAT.
REQ-017 SHALL, for opcode 0x03 VERTEX, at +1 pulse mul_en with type 0 and mode_out 1.
REQ-018 SHALL, for VERTEX, at +1+MM_LAT pulse mul_en with type 0 and mode_out 0.
REQ-019 SHALL, for VERTEX, at +1+2*MM_LAT pulse perspective_div_en, and raise cmd_ready at +1+2*MM_LAT+DIV_LAT.
REQ-020 SHALL, for opcode 0x13 LOADMATRIX, hold matrix_load_en high from +1 to +LOAD_ROWS inclusive, with mode_out = curr_mode.
REQ-021 SHALL, for LOADMATRIX, drive bram_addr_out = bram_addr_in + i*ADDR_STEP at +1+i for i = 0..LOAD_ROWS-1, and raise cmd_ready at +1+LOAD_ROWS.
REQ-022 SHALL compute LOADMATRIX addresses modulo 2^32, wrapping silently.
REQ-023 SHALL, for opcode 0x04 COLOR, drive bram_addr_out = bram_addr_in at +1, load color_out from bram_rd_data words 0..NCH-1 at +2, and raise cmd_ready at +2.
REQ-024 SHALL, for opcode 0x19 VIEWPORT, behave as COLOR but load all four words into viewport_out.
REQ-025 SHALL keep a separate depth counter per matrix mode, each ranging 0..STACK_DEPTH.
REQ-026 SHALL, for PUSH (0x14), at +1 pulse push_en and increment depth[curr_mode]; if that depth equals STACK_DEPTH it SHALL instead pulse stack_err with no push_en and no depth change.
REQ-027 SHALL, for POP (0x15), at +1 pulse pop_en and decrement depth[curr_mode]; if that depth is 0 it SHALL instead pulse stack_err with no pop_en and no depth change.
REQ-028 SHALL treat all other opcodes (BEGIN, END, FRUSTUM, undefined) as NOPs: accepted, with no output change.
REQ-029 SHALL ignore cmd_valid, opcode and imm while not in IDLE.

Reset
REQ-030 SHALL, when reset is high on an edge, return to IDLE regardless of state, with cmd_ready = 1, all pulses and matrix_load_en at 0, matrix_mul_type = 0, matrix_mode_out = 0, curr_mode = 0 and bram_addr_out = 0.
REQ-031 SHALL at the same reset set color_out to 0, viewport_out to {0, 0, 0x44200000, 0x43F00000} and both depth counters to 0.
REQ-032 SHALL give reset priority over a simultaneous accept, discarding the command.

Verification
REQ-033 SHALL verify, with MM_LAT=4 and DIV_LAT=2, that VERTEX gives mul_en pulses at +1 (mode 1) and +5 (mode 0), perspective_div_en at +9, and cmd_ready returning at +11.
REQ-034 SHALL verify that LOADMATRIX with bram_addr_in 0x100 gives addresses 0x100, 0x110, 0x120, 0x130 on +1..+4, load_en high for exactly 4 cycles, and ready at +5.
REQ-035 SHALL verify that MATRIXMODE imm=0 followed by 9 PUSHes with STACK_DEPTH=8 gives 8 push_en pulses, then a stack_err pulse, with projection depth 8 and modelview depth 0.
REQ-036 SHALL verify that POP with depth 0 gives a stack_err pulse and no pop_en, and that a following PUSH and POP each succeed.
REQ-037 SHALL verify that COLOR with bram_rd_data words {1.0, 0.5, 0.25} and NCH=3 gives color_out equal to those values at +2.
REQ-038 SHALL verify that reset asserted at +3 of MULT clears all pulses and gives cmd_ready=1 on the next cycle, with a new command accepted immediately after.
